// File: rtl/jstk_txn_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : jstk_txn_scheduler_if
// Brief    : Colour-request, PmodJSTK and position/status signal bundle for
//            the joystick transaction scheduler.
// Revision : 1.0
// ============================================================================
interface jstk_txn_scheduler_if;
    logic        color_req;
    logic [23:0] color_data;
    logic        color_ack;
    logic        snd_rec;
    logic [39:0] din;
    logic        ss;
    logic [39:0] dout;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic [2:0]  buttons;
    logic        data_valid;
    logic        busy;
    logic        timeout_err;

    // Scheduler side
    modport slave (
        input  color_req, color_data, ss, dout,
        output color_ack, snd_rec, din, xpos, ypos, buttons,
               data_valid, busy, timeout_err
    );

    // Requester / PmodJSTK / consumer side
    modport master (
        output color_req, color_data, ss, dout,
        input  color_ack, snd_rec, din, xpos, ypos, buttons,
               data_valid, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/jstk_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : jstk_txn_scheduler
// Brief    : Sequences PmodJSTK SPI transactions (periodic poll or colour
//            update), tracks SS to completion and decodes DOUT into X/Y/
//            button outputs. Define JSTK_SCHED_AVG_EN for two-sample X/Y
//            averaging.
// Revision : 1.0
// ============================================================================
module jstk_txn_scheduler #(
    parameter int CLK_HZ      = 12000000,
    parameter int POLL_HZ     = 10,
    parameter int TIMEOUT_CYC = 240000,
    parameter int GAP_CYC     = 12
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    jstk_txn_scheduler_if.slave bus
);

    localparam int c_POLL_CYC = CLK_HZ / POLL_HZ;
    localparam int c_POLL_W   = (c_POLL_CYC > 1) ? $clog2(c_POLL_CYC) : 1;
    localparam int c_TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [c_POLL_W-1:0] c_POLL_RELOAD = c_POLL_W'(c_POLL_CYC - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST     = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST    = c_GAP_W'(GAP_CYC);
    localparam logic [9:0]          c_MID         = 10'd512;
    localparam logic [7:0]          c_CMD_LED     = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_XFER    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_POLL_W-1:0]   r_poll_cnt;
    logic                  r_poll_pend;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic [c_GAP_W-1:0]    r_gap_cnt;
    logic                  r_ss_prev;
    logic [23:0]           r_color;
    logic                  r_color_ack;
    logic                  r_data_valid;
    logic                  r_timeout_err;
    logic [9:0]            r_xpos;
    logic [9:0]            r_ypos;
    logic [2:0]            r_buttons;

    logic                  w_poll_tick;
    logic                  w_to_hit;
    logic                  w_ss_rise;
    logic                  w_gap_done;
    logic                  w_take_color;
    logic                  w_leave_idle;
    logic                  w_capture;
    logic                  w_abort;
    logic [9:0]            w_x_raw;
    logic [9:0]            w_y_raw;
    logic                  w_unused;

    assign w_poll_tick = (r_poll_cnt == '0);
    assign w_to_hit    = (r_to_cnt == c_TO_LAST);
    assign w_ss_rise   = ~r_ss_prev & bus.ss;
    assign w_gap_done  = (r_gap_cnt == c_GAP_LAST);
    assign w_x_raw     = {bus.dout[9:8], bus.dout[23:16]};
    assign w_y_raw     = {bus.dout[25:24], bus.dout[39:32]};
    assign w_unused    = ^{bus.dout[31:26], bus.dout[15:10], bus.dout[7:3]};

    // Free-running poll timer; period is independent of transaction activity
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_poll_cnt <= c_POLL_RELOAD;
        end else if (w_poll_tick) begin
            r_poll_cnt <= c_POLL_RELOAD;
        end else begin
            r_poll_cnt <= r_poll_cnt - 1'b1;
        end
    end

    // A tick coinciding with leaving IDLE must survive, hence tick wins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_poll_pend <= 1'b0;
        end else if (w_poll_tick) begin
            r_poll_pend <= 1'b1;
        end else if (w_leave_idle) begin
            r_poll_pend <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_take_color = 1'b0;
        w_leave_idle = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.color_req) begin
                    w_take_color = 1'b1;
                    w_leave_idle = 1'b1;
                    w_state_nxt  = ST_START;
                end else if (r_poll_pend) begin
                    w_leave_idle = 1'b1;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (w_to_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (!bus.ss) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_to_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (w_ss_rise) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timeout window spans START and XFER together
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_to_cnt <= '0;
        end else if (w_leave_idle) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_START) || (r_state == ST_XFER)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gap_cnt <= '0;
        end else if (r_state != ST_GAP) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // SS idles high, so a reset value of 1 cannot fake a rising edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ss_prev <= 1'b1;
        end else begin
            r_ss_prev <= bus.ss;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_color       <= '0;
            r_color_ack   <= 1'b0;
            r_data_valid  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_color_ack  <= w_take_color;
            r_data_valid <= w_capture;
            if (w_take_color) begin
                r_color <= bus.color_data;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end else if (w_capture) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

`ifdef JSTK_SCHED_AVG_EN
    logic [9:0]  r_x_prev;
    logic [9:0]  r_y_prev;
    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;

    assign w_x_sum = {1'b0, r_x_prev} + {1'b0, w_x_raw};
    assign w_y_sum = {1'b0, r_y_prev} + {1'b0, w_y_raw};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_x_prev  <= c_MID;
            r_y_prev  <= c_MID;
            r_xpos    <= c_MID;
            r_ypos    <= c_MID;
            r_buttons <= '0;
        end else if (w_capture) begin
            r_x_prev  <= w_x_raw;
            r_y_prev  <= w_y_raw;
            r_xpos    <= w_x_sum[10:1];
            r_ypos    <= w_y_sum[10:1];
            r_buttons <= bus.dout[2:0];
        end
    end
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_xpos    <= c_MID;
            r_ypos    <= c_MID;
            r_buttons <= '0;
        end else if (w_capture) begin
            r_xpos    <= w_x_raw;
            r_ypos    <= w_y_raw;
            r_buttons <= bus.dout[2:0];
        end
    end
`endif

    // snd_rec decodes straight from state so an async reset drops it at once
    assign bus.snd_rec     = (r_state == ST_START);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.din         = {c_CMD_LED, r_color, 8'h00};
    assign bus.color_ack   = r_color_ack;
    assign bus.data_valid  = r_data_valid;
    assign bus.timeout_err = r_timeout_err;
    assign bus.xpos        = r_xpos;
    assign bus.ypos        = r_ypos;
    assign bus.buttons     = r_buttons;

endmodule
`default_nettype wire

// File: doc/jstk_txn_scheduler.md
# jstk_txn_scheduler

Transaction scheduler for the PmodJSTK SPI interface. It replaces the free-running 10 Hz `sndRec` generator with a controlled sequencer. It arbitrates between the periodic position poll and on-demand LED-colour update requests, builds the 40-bit outbound frame, and drives `sndRec`. It watches `SS` to track each transfer to completion, then captures and decodes `DOUT` into registered X/Y/button outputs with a valid strobe. It sits between `PmodJSTK`, the colour-selection logic and the LED/position consumers.

## Interface
Parameters:
- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `POLL_HZ`, 10, periodic poll rate in Hz; poll period is `CLK_HZ/POLL_HZ` cycles.
- `TIMEOUT_CYC`, 240000, maximum cycles allowed in START+XFER before abort (20 ms at 12 MHz).
- `GAP_CYC`, 12, minimum idle cycles between transactions.

Ports:
- `CLK`  in  1  system clock; one clock, all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `color_req`  in  1  level request to send a new RGB colour.
- `color_data`  in  24  RGB value; sampled when `color_ack` pulses.
- `color_ack`  out  1  one-cycle pulse when `color_data` is accepted.
- `snd_rec`  out  1  to `PmodJSTK.sndRec`.
- `din`  out  40  to `PmodJSTK.DIN`.
- `ss`  in  1  from `PmodJSTK.SS`, active-low, same clock domain.
- `dout`  in  40  from `PmodJSTK.DOUT`.
- `xpos`  out  10  joystick X, 0..1023.
- `ypos`  out  10  joystick Y, 0..1023.
- `buttons`  out  3  `dout[2:0]` (trigger, joystick button, pushbutton).
- `data_valid`  out  1  one-cycle pulse on new capture.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; set on abort, cleared by the next successful capture.

## Operation
- Poll timer:
  - Free-running down-counter of `CLK_HZ/POLL_HZ` cycles.
  - On wrap it sets `poll_pend`.
- Colour register:
  - 24 bits, reset 0.
  - `din` = {8'h84, colour, 8'h00} at all times.
- FSM states:
  - IDLE: if `color_req`, load colour from `color_data`, pulse `color_ack`, go to START. Otherwise, if `poll_pend`, go to START. Leaving IDLE clears `poll_pend`; a poll tick on that same edge re-sets it.
  - START: `snd_rec`=1. When `ss`=0, deassert `snd_rec` and go to XFER.
  - XFER: `snd_rec`=0. On `ss` rising (registered previous `ss`=0, current `ss`=1), go to CAPTURE.
  - CAPTURE: one cycle. Latch:
    - `ypos` = {`dout[25:24]`, `dout[39:32]`}
    - `xpos` = {`dout[9:8]`, `dout[23:16]`}
    - `buttons` = `dout[2:0]`
    
    Pulse `data_valid`, clear `timeout_err`, go to GAP.
  - GAP: count `GAP_CYC` cycles, then go to IDLE.
- Arbitration:
  - When `color_req` and `poll_pend` are both present, the colour request wins.
  - Its frame also returns position data, so `poll_pend` is cleared and no extra transaction is issued.
- Timeout:
  - One counter runs across START+XFER and is cleared on entry to START.
  - On reaching `TIMEOUT_CYC`: `snd_rec`=0, set `timeout_err`, go to GAP, no `data_valid`, outputs hold their previous values.
- `color_req` arriving while busy is held until the next IDLE. The request is level-sensitive; the requester drops it after `color_ack`.

## Timing
- Reset values:
  - `snd_rec`=0, `color_ack`=0, `data_valid`=0, `busy`=0, `timeout_err`=0
  - `din`=40'h84_000000_00
  - `xpos`=`ypos`=10'd512, `buttons`=0
  - poll counter reloaded, `poll_pend`=0
- `color_ack` and the updated `din` appear on the same edge that enters START; `snd_rec` rises on that edge too.
- `snd_rec` falls on the edge after the first cycle sampling `ss`=0.
- `ss` rising sampled at edge n: outputs updated and `data_valid`=1 during cycle n+1; IDLE reached at n+2+`GAP_CYC`.
- Back-to-back transactions are separated by at least `GAP_CYC`+1 cycles of `snd_rec`=0.
- `RST` asserted mid-transaction: all state returns asynchronously to IDLE and `snd_rec` drops immediately. `PmodJSTK` is reset by the same `RST`.

## Configuration
- `JSTK_SCHED_AVG_EN` defined:
  - `xpos`/`ypos` output the two-sample average (prev + new) >> 1, using an 11-bit sum with truncation.
  - The previous-sample registers reset to 512 and update on every capture.
- Undefined: raw decoded values are output; no previous-sample registers exist.
- `buttons` is never averaged.

## Test plan
- Reset, then a PmodJSTK model returning `dout`=40'hC8_01_F0_03_05 -> first poll after `CLK_HZ/POLL_HZ` cycles; `xpos`=10'h3F0, `ypos`=10'h1C8, `buttons`=3'b101, one `data_valid` pulse.
- `color_req` with `color_data`=24'h00FF00 while idle -> `color_ack` one cycle; `din`=40'h84_00FF00_00 on the START edge; exactly one transaction.
- `color_req` and poll tick in the same cycle -> a single colour transaction; no second transaction until the next poll tick.
- Model never drops `ss` -> `snd_rec` falls after `TIMEOUT_CYC` cycles, `timeout_err`=1, no `data_valid`, outputs unchanged; the next good transaction clears `timeout_err`.
- `RST` pulse during XFER -> `snd_rec`=0, `busy`=0, `xpos`=512 immediately; normal polling resumes.
- With `JSTK_SCHED_AVG_EN` defined, successive X samples of 1000 then 0 -> `xpos`=756, then 500.
